// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter with back-to-back frames
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 5208,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx_done,
  output logic       overflow,
  output logic       TX
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  typedef enum logic {IDLE, XMIT} state_t;
  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [9:0]    shreg;
  logic [12:0]   baud_cnt;
  logic [3:0]    bit_cnt;
  logic          push, pop, tick, last;
  assign full  = count == FULL_CNT;
  assign empty = count == '0;
  assign TX    = shreg[0];
  assign tick  = state == XMIT && baud_cnt == 13'(BAUD_DIV - 1);
  // stop bit finishing: the next frame may load on this same edge
  assign last  = tick && bit_cnt == 4'd9;
  assign push  = trmt && !full;
  assign pop   = !empty && (state == IDLE || last);
  always_ff @(posedge clk)
    if (push) mem[wptr] <= tx_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      shreg    <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      tx_done  <= last;
      overflow <= overflow | (trmt && full);
      count    <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (pop) begin
        shreg    <= {1'b1, mem[rptr], 1'b0};
        baud_cnt <= '0;
        bit_cnt  <= '0;
        state    <= XMIT;
        busy     <= 1'b1;
      end else if (tick) begin
        shreg    <= {1'b1, shreg[9:1]};
        baud_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
        state    <= last ? IDLE : XMIT;
        busy     <= !last;
      end else if (state == XMIT) begin
        baud_cnt <= baud_cnt + 13'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench with frame-level model and serial decoder
module tb_uart_tx_fifo;
  localparam int BD = 16, DEPTH = 4;
  logic clk = 0, rst = 1, trmt = 0;
  logic [7:0] tx_data = 0;
  logic full, empty, busy, tx_done, overflow, TX;
  uart_tx_fifo #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .trmt(trmt), .full(full), .empty(empty),
    .busy(busy), .tx_done(tx_done), .overflow(overflow), .TX(TX));
  always #5 clk = ~clk;
  int tests = 0, fails = 0, cyc = 0, done_cnt = 0, rx_t = 0;
  bit rx_act = 0;
  logic [7:0] rx_b;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  // model: queued bytes, current frame byte, clocks elapsed in the frame
  byte unsigned mq[$], exp_q[$], cur;
  int start_q[$];
  bit mbusy = 0, movf = 0, mdone = 0, end_now, do_pop, acc;
  int fcnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); exp_q.delete();
      mbusy = 0; movf = 0; mdone = 0; fcnt = 0;
    end else begin
      end_now = mbusy && fcnt + 1 == 10 * BD;
      do_pop  = mq.size() > 0 && (!mbusy || end_now);
      acc     = trmt && mq.size() < DEPTH;
      mdone   = end_now;
      if (trmt && !acc) movf = 1;
      if (mbusy) fcnt++;
      if (end_now && !do_pop) mbusy = 0;
      if (do_pop) begin cur = mq.pop_front(); mbusy = 1; fcnt = 0; end
      if (acc) begin mq.push_back(tx_data); exp_q.push_back(tx_data); end
    end
  end
  function automatic bit etx();
    int k = fcnt / BD;
    if (!mbusy) return 1'b1;
    return k == 0 ? 1'b0 : k == 9 ? 1'b1 : cur[k-1];
  endfunction
  always @(negedge clk) begin
    cyc++;
    chk("full", full, mq.size() == DEPTH);
    chk("empty", empty, mq.size() == 0);
    chk("busy", busy, mbusy);
    chk("overflow", overflow, movf);
    chk("tx_line", TX, etx());
    chk("tx_done", tx_done, mdone);
    if (rst) begin
      rx_act = 0;
      start_q.delete();
    end else if (!rx_act) begin
      if (TX === 1'b0) begin rx_act = 1; rx_t = 0; start_q.push_back(cyc); end
    end else rx_t++;
    if (rx_act && rx_t % BD == BD / 2) begin
      if (rx_t / BD == 0) chk("rx_start", TX, 0);
      else if (rx_t / BD < 9) rx_b[rx_t / BD - 1] = TX;
      else begin
        chk("rx_stop", TX, 1);
        rx_act = 0;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rx_unexpected: got frame %0h expected none", rx_b);
        end else if (rx_b !== exp_q[0]) begin
          fails++;
          $display("FAIL rx_byte: got %0h expected %0h", rx_b, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    if (!rst && tx_done === 1'b1) begin
      done_cnt++;
      tests++;
      if (start_q.size() == 0) begin
        fails++;
        $display("FAIL done_orphan: got tx_done expected no pulse");
      end else chk("done_gap", cyc - start_q.pop_front(), 10 * BD);
    end
  end
  task automatic push(input logic [7:0] b);
    tx_data = b; trmt = 1;
    @(negedge clk);
    trmt = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((mbusy || mq.size() != 0 || rx_act) && n < 4000) begin @(negedge clk); n++; end
    tests++;
    if (n >= 4000) begin fails++; $display("FAIL wait_idle: got timeout expected idle"); end
    repeat (2) @(negedge clk);
  endtask
  task automatic reset_pulse();
    rst = 1; @(negedge clk); rst = 0; @(negedge clk);
  endtask
  initial begin
    int d0, n;
    repeat (3) @(negedge clk);
    chk("rst_tx", TX, 1); chk("rst_full", full, 0); chk("rst_empty", empty, 1);
    chk("rst_busy", busy, 0); chk("rst_done", tx_done, 0); chk("rst_ovf", overflow, 0);
    rst = 0;
    @(negedge clk);
    d0 = done_cnt;
    push(8'hA5);
    chk("t1_tx_high", TX, 1);
    @(negedge clk);
    chk("t1_tx_low", TX, 0);
    wait_idle();
    chk("t1_empty", empty, 1); chk("t1_busy", busy, 0); chk("t1_dones", done_cnt - d0, 1);
    d0 = done_cnt;
    push(8'h11); push(8'h22); push(8'h33);
    wait_idle();
    chk("t2_dones", done_cnt - d0, 3);
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
    chk("t3_full", full, 1); chk("t3_ovf", overflow, 1);
    wait_idle();
    chk("t3_ovf_sticky", overflow, 1); chk("t3_dones", done_cnt - d0, 5);
    reset_pulse();
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    n = 0;
    while (!(mbusy && fcnt == 10 * BD - 1) && n < 400) begin @(negedge clk); n++; end
    chk("t4_reach_end", n < 400, 1);
    push(8'hEE);
    chk("t4_ovf", overflow, 1); chk("t4_full", full, 0); chk("t4_empty", empty, 0);
    wait_idle();
    reset_pulse();
    push(8'h3C); push(8'h4D); push(8'h5E);
    n = 0;
    while (!(mbusy && fcnt == 5 * BD + 4) && n < 400) begin @(negedge clk); n++; end
    rst = 1;
    @(negedge clk);
    chk("t5_tx", TX, 1); chk("t5_empty", empty, 1); chk("t5_busy", busy, 0);
    rst = 0;
    d0 = done_cnt;
    repeat (400) @(negedge clk);
    chk("t5_no_done", done_cnt - d0, 0); chk("t5_tx_idle", TX, 1);
    push(8'h00); push(8'hFF); push(8'h5A);
    wait_idle();
    for (int i = 0; i < 3000; i++) begin
      tx_data = 8'($urandom);
      trmt = $urandom_range(0, 40) == 0;
      @(negedge clk);
    end
    trmt = 0;
    wait_idle();
    chk("end_scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
